// File: rtl/jk_pkg.sv
// +--------------------------------------------------------------------+
// | jk_pkg: JK op codes, arbiter FSM states and the JK next-state rule. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package jk_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Ops are encoded as {J,K}.
    function automatic logic jk_next(input logic q, input logic [1:0] op);
        logic r;
        case (op)
            OP_HOLD: r = q;
            OP_RST:  r = 1'b0;
            OP_SET:  r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// +--------------------------------------------------------------------+
// | jk_cell: single JK flip-flop with enable and async active-low rst. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= jk_next(q, {j, k});
        end
    end

endmodule

`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
// +--------------------------------------------------------------------+
// | jk_bank_arbiter: two-requester round-robin access to a JK bank,    |
// | with a one-bit-per-cycle clear sweep.                              |
// | Optional: JK_SAME_IDX_MERGE_EN merges same-index requests.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [IDXW-1:0]  req0_idx,
    input  logic [1:0]       req0_op,
    input  logic [IDXW-1:0]  req1_idx,
    input  logic [1:0]       req1_op,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic [1:0]       rsp_valid,
    output logic [1:0]       rsp_q,
    output logic [WIDTH-1:0] q
);

    localparam int c_NPAD = 1 << IDXW;

    state_t            r_state;
    logic [IDXW-1:0]   r_clr_cnt;
    logic              r_prio;
    logic [1:0]        r_rsp_valid;
    logic [1:0]        r_rsp_q;

    logic [1:0]        w_ready;
    logic              w_merge;
    logic              w_sel;
    logic [IDXW-1:0]   w_idx;
    logic [1:0]        w_op;
    logic              w_next;
    logic [c_NPAD-1:0] w_q_pad;

    function automatic logic idx_ok(input logic [IDXW-1:0] idx);
        return (int'(idx) < WIDTH);
    endfunction

    // Grants are suppressed during reset, during a sweep and on the clr_start cycle.
    always_comb begin
        w_ready = 2'b00;
        w_merge = 1'b0;
        w_sel   = 1'b0;
        if (rst && (r_state == ST_IDLE) && !clr_start) begin
`ifdef JK_SAME_IDX_MERGE_EN
            if ((req_valid == 2'b11) && (req0_idx == req1_idx) && idx_ok(req0_idx)) begin
                w_merge = 1'b1;
                w_ready = 2'b11;
            end else
`endif
            if (req_valid == 2'b11) begin
                w_sel   = r_prio;
                w_ready = r_prio ? 2'b10 : 2'b01;
            end else if (req_valid[1]) begin
                w_sel   = 1'b1;
                w_ready = 2'b10;
            end else if (req_valid[0]) begin
                w_sel   = 1'b0;
                w_ready = 2'b01;
            end
        end
    end

    assign req_ready = w_ready;
    assign clr_busy  = (r_state == ST_CLEAR);
    assign rsp_valid = r_rsp_valid;
    assign rsp_q     = r_rsp_q;

    assign w_idx   = w_sel ? req1_idx : req0_idx;
    assign w_op    = w_merge ? (req0_op | req1_op) : (w_sel ? req1_op : req0_op);
    assign w_q_pad = c_NPAD'(q);
    assign w_next  = idx_ok(w_idx) ? jk_next(w_q_pad[w_idx], w_op) : 1'b0;

    // Out-of-range indices match no cell, so they act as hold.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
        logic w_hit_clr;
        logic w_hit_req;
        assign w_hit_clr = (r_state == ST_CLEAR) && (r_clr_cnt == IDXW'(gi));
        assign w_hit_req = (|w_ready) && (w_idx == IDXW'(gi));

        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (w_hit_clr | w_hit_req),
            .j   (w_hit_req & w_op[1]),
            .k   (w_hit_clr | w_op[0]),
            .q   (q[gi])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_clr_cnt   <= '0;
            r_prio      <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_q     <= 2'b00;
        end else begin
            r_rsp_valid <= w_ready;
            r_rsp_q[0]  <= w_ready[0] & w_next;
            r_rsp_q[1]  <= w_ready[1] & w_next;
            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end else if ((|w_ready) && !w_merge) begin
                        r_prio <= ~w_sel;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == IDXW'(WIDTH - 1)) begin
                        r_state   <= ST_IDLE;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_jk_bank_arbiter: directed and random checks against a bank model.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [2:0] req0_idx = '0, req1_idx = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic [1:0] rsp_valid, rsp_q;
    logic [7:0] q;

    logic [1:0] s_valid = '0;
    logic [1:0] s_ready;
    logic [2:0] s_i0 = '0, s_i1 = '0;
    logic [1:0] s_o0 = '0, s_o1 = '0;
    logic       s_clr = 1'b0;
    logic       s_busy;
    logic [1:0] s_rsp_valid, s_rsp_q;
    logic [5:0] s_q;

    int ntests = 0;
    int nfail  = 0;

    bit [7:0] mq;
    int       clr_left;
    int       favour;
    bit [1:0] erv, erq;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_idx(req0_idx), .req0_op(req0_op), .req1_idx(req1_idx), .req1_op(req1_op),
        .clr_start(clr_start), .clr_busy(clr_busy), .rsp_valid(rsp_valid),
        .rsp_q(rsp_q), .q(q)
    );

    jk_bank_arbiter #(.WIDTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s_ready),
        .req0_idx(s_i0), .req0_op(s_o0), .req1_idx(s_i1), .req1_op(s_o1),
        .clr_start(s_clr), .clr_busy(s_busy), .rsp_valid(s_rsp_valid),
        .rsp_q(s_rsp_q), .q(s_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit apply(input bit b, input bit [1:0] op);
        case (op)
            2'd0:    return b;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return !b;
        endcase
    endfunction

    // One clock: drive, check the grant, advance the model, check registered outputs.
    task automatic cyc(input bit [1:0] v, input bit [2:0] i0, input bit [1:0] o0,
                       input bit [2:0] i1, input bit [1:0] o1, input bit cs);
        bit [1:0] g;
        int       t;
        bit [2:0] ix;
        bit [1:0] op;
        req_valid = v; req0_idx = i0; req0_op = o0;
        req1_idx = i1; req1_op = o1; clr_start = cs;
        #1;
        g = 2'b00;
        if (clr_left == 0 && !cs) begin
`ifdef JK_SAME_IDX_MERGE_EN
            if (v == 2'b11 && i0 == i1) g = 2'b11; else
`endif
            if (v == 2'b11) g = (favour == 0) ? 2'b01 : 2'b10;
            else g = v;
        end
        chk("ready", req_ready, g);
        @(posedge clk);
        erv = g;
        erq = 2'b00;
        if (clr_left > 0) begin
            mq[8 - clr_left] = 1'b0;
            clr_left--;
        end else if (cs) begin
            clr_left = 8;
        end else if (g == 2'b11) begin
            mq[i0] = apply(mq[i0], o0 | o1);
            erq = {mq[i0], mq[i0]};
        end else if (g != 2'b00) begin
            t  = g[0] ? 0 : 1;
            ix = (t == 0) ? i0 : i1;
            op = (t == 0) ? o0 : o1;
            mq[ix] = apply(mq[ix], op);
            erq[t] = mq[ix];
            favour = 1 - t;
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, erv);
        chk("rsp_q", rsp_q, erq);
        chk("q", q, mq);
        chk("clr_busy", clr_busy, (clr_left > 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b0; req_valid = 2'b11; clr_start = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_q", rsp_q, 0);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        mq = '0; clr_left = 0; favour = 0; erv = '0; erq = '0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Out-of-range index on a 6-bit bank, then a normal set on bit 5.
        s_valid = 2'b10; s_i1 = 3'd7; s_o1 = 2'b10;
        #1 chk("w6_oor_ready", s_ready, 2'b10);
        @(negedge clk);
        s_i1 = 3'd5;
        chk("w6_oor_q", s_q, 6'h00);
        chk("w6_oor_rsp_valid", s_rsp_valid, 2'b10);
        chk("w6_oor_rsp_q", s_rsp_q, 2'b00);
        @(negedge clk);
        s_valid = 2'b00;
        chk("w6_set_q", s_q, 6'h20);
        chk("w6_set_rsp_q", s_rsp_q, 2'b10);

        // Single request set then toggle.
        cyc(2'b01, 3'd3, 2'b10, 3'd0, 2'b00, 1'b0);
        chk("t1_q_set", q, 8'h08);
        cyc(2'b01, 3'd3, 2'b11, 3'd0, 2'b00, 1'b0);
        chk("t1_q_tgl", q, 8'h00);
        cyc(2'b00, 3'd0, 2'b00, 3'd0, 2'b00, 1'b0);

        // Round robin from reset.
        do_reset();
        repeat (4) cyc(2'b11, 3'd0, 2'b10, 3'd1, 2'b10, 1'b0);
        chk("t2_q", q, 8'h03);

        // Clear sweep from a full bank with req0 waiting.
        for (int i = 0; i < 8; i++) cyc(2'b10, 3'd0, 2'b00, 3'(i), 2'b10, 1'b0);
        chk("t3_preload", q, 8'hFF);
        cyc(2'b01, 3'd2, 2'b10, 3'd0, 2'b00, 1'b1);
        repeat (8) cyc(2'b01, 3'd2, 2'b10, 3'd0, 2'b00, 1'b0);
        chk("t3_swept", q, 8'h00);
        cyc(2'b01, 3'd2, 2'b10, 3'd0, 2'b00, 1'b0);

        // Reset in the middle of a sweep.
        cyc(2'b10, 3'd0, 2'b00, 3'd7, 2'b10, 1'b0);
        cyc(2'b10, 3'd0, 2'b00, 3'd6, 2'b10, 1'b0);
        cyc(2'b00, 3'd0, 2'b00, 3'd0, 2'b00, 1'b1);
        repeat (4) cyc(2'b00, 3'd0, 2'b00, 3'd0, 2'b00, 1'b0);
        rst = 1'b0;
        #1;
        chk("t4_q", q, 0);
        chk("t4_busy", clr_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        mq = '0; clr_left = 0; favour = 0; erv = '0; erq = '0;
        cyc(2'b01, 3'd1, 2'b10, 3'd0, 2'b00, 1'b0);

        // Both requesters on the same index.
        do_reset();
`ifdef JK_SAME_IDX_MERGE_EN
        cyc(2'b11, 3'd5, 2'b10, 3'd5, 2'b01, 1'b0);
        chk("t6_rsp_valid", rsp_valid, 2'b11);
        cyc(2'b00, 3'd0, 2'b00, 3'd0, 2'b00, 1'b0);
        chk("t6_q5", q[5], 1'b1);
`else
        cyc(2'b11, 3'd5, 2'b10, 3'd5, 2'b01, 1'b0);
        cyc(2'b11, 3'd5, 2'b10, 3'd5, 2'b01, 1'b0);
        cyc(2'b00, 3'd0, 2'b00, 3'd0, 2'b00, 1'b0);
        chk("t6_q5", q[5], 1'b0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            bit [2:0] a, b;
            a = 3'($urandom_range(0, 7));
            b = ($urandom_range(0, 2) == 0) ? a : 3'($urandom_range(0, 7));
            cyc(2'($urandom_range(0, 3)), a, 2'($urandom_range(0, 3)),
                b, 2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
